ticket_buyer: RTL and testbench

TICKET_BUYER -- requirements
Module: ticket_buyer

---
 rtl/ticket_buyer.sv | 121 ++++++++++++
 tb/tb_ticket_buyer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ticket_buyer.sv
// ticket_buyer: drives a ticket vendor with destination, count and coin pulses,
// then tallies tickets and change returned until the vendor goes quiet.
module ticket_buyer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dest_in,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] pay_in,
    output logic [WIDTH-1:0] dest,
    output logic [WIDTH-1:0] count,
    output logic             one_insert,
    output logic             ten_insert,
    output logic             done,
    input  logic             ticket,
    input  logic             one_output,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] tickets_rcvd,
    output logic [WIDTH-1:0] change_rcvd
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

    typedef enum logic [3:0] {
        IDLE, SETUP, TEN_HI, TEN_LO, ONE_HI, ONE_LO, DONE1, DONE2, COLLECT, REPORT
    } state_t;

    state_t           state;
    state_t           nxt_pay;
    logic [WIDTH-1:0] tens, ones;
    logic [CW-1:0]    idle;
    logic             ticket_q, one_q;
    logic             tick_edge, chg_edge, counting;

    assign tick_edge = ticket & ~ticket_q;
    assign chg_edge  = one_output & ~one_q;
    assign counting  = state == DONE1 || state == DONE2 || state == COLLECT;
    // tens are always exhausted before ones are considered
    assign nxt_pay   = tens != '0 ? TEN_HI : ones != '0 ? ONE_HI : DONE1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dest         <= '0;
            count        <= '0;
            tens         <= '0;
            ones         <= '0;
            idle         <= '0;
            one_insert   <= 1'b0;
            ten_insert   <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            tickets_rcvd <= '0;
            change_rcvd  <= '0;
            ticket_q     <= 1'b0;
            one_q        <= 1'b0;
        end else begin
            ticket_q <= ticket;
            one_q    <= one_output;
            if (counting && tick_edge && tickets_rcvd != '1)
                tickets_rcvd <= tickets_rcvd + 1'b1;
            if (counting && chg_edge && change_rcvd != '1)
                change_rcvd <= change_rcvd + 1'b1;
            case (state)
                IDLE: if (start) begin
                    dest         <= dest_in;
                    count        <= count_in;
                    tens         <= pay_in / TEN;
                    ones         <= pay_in % TEN;
                    tickets_rcvd <= '0;
                    change_rcvd  <= '0;
                    busy         <= 1'b1;
                    state        <= SETUP;
                end
                SETUP, TEN_LO, ONE_LO: begin
                    state      <= nxt_pay;
                    ten_insert <= nxt_pay == TEN_HI;
                    one_insert <= nxt_pay == ONE_HI;
                    done       <= nxt_pay == DONE1;
                end
                TEN_HI: begin
                    tens       <= tens - 1'b1;
                    ten_insert <= 1'b0;
                    state      <= TEN_LO;
                end
                ONE_HI: begin
                    ones       <= ones - 1'b1;
                    one_insert <= 1'b0;
                    state      <= ONE_LO;
                end
                DONE1: state <= DONE2;
                DONE2: begin
                    done  <= 1'b0;
                    idle  <= '0;
                    state <= COLLECT;
                end
                COLLECT: begin
                    if (tick_edge || chg_edge) begin
                        idle <= '0;
                    end else if (idle == CW'(TIMEOUT - 1)) begin
                        result_valid <= 1'b1;
                        state        <= REPORT;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end
                REPORT: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ticket_buyer.sv
// tb_ticket_buyer: scoreboard bench for ticket_buyer; expected tallies are queued
// per accepted start and checked whenever result_valid pulses.
module tb_ticket_buyer;
    localparam int W = 8;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dest_in = '0, count_in = '0, pay_in = '0;
    logic [W-1:0] dest, count, tickets_rcvd, change_rcvd;
    logic         one_insert, ten_insert, done, busy, result_valid;
    logic         ticket = 1'b0, one_output = 1'b0;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    ticket_buyer #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dest_in(dest_in), .count_in(count_in), .pay_in(pay_in),
        .dest(dest), .count(count),
        .one_insert(one_insert), .ten_insert(ten_insert), .done(done),
        .ticket(ticket), .one_output(one_output),
        .busy(busy), .result_valid(result_valid),
        .tickets_rcvd(tickets_rcvd), .change_rcvd(change_rcvd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (result_valid) begin
            check("rv_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("tickets", 32'(tickets_rcvd), 32'(e[15:8]));
                check("change", 32'(change_rcvd), 32'(e[7:0]));
            end
        end
    end

    task automatic run(input logic [W-1:0] d, input logic [W-1:0] c, input logic [W-1:0] p,
                       input int nt, input int ht, input int nc, input bit glitch);
        int tn, on, n;
        logic e_ten, e_one, e_dn;
        tn = int'(p) / 10;
        on = int'(p) % 10;
        exp_q.push_back({8'(nt > 255 ? 255 : nt), 8'(nc > 255 ? 255 : nc)});
        @(negedge clk);
        dest_in = d; count_in = c; pay_in = p; start = 1'b1;
        @(posedge clk); #1;
        check("setup_busy", 32'(busy), 1);
        check("setup_quiet", 32'({ten_insert, one_insert, done}), 0);
        check("latch_dest", 32'(dest), 32'(d));
        check("latch_count", 32'(count), 32'(c));
        @(negedge clk);
        start = glitch; dest_in = ~d; count_in = ~c;
        for (int i = 0; i < 2 * tn + 2 * on + 2; i++) begin
            @(posedge clk); #1;
            e_ten = i < 2 * tn && i % 2 == 0;
            e_one = i >= 2 * tn && i < 2 * tn + 2 * on && i % 2 == 0;
            e_dn  = i >= 2 * tn + 2 * on;
            check("coins", 32'({ten_insert, one_insert, done}), 32'({e_ten, e_one, e_dn}));
            check("hold_dest", 32'({dest, count}), 32'({d, c}));
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < nt; k++) begin
            ticket = 1'b1;
            repeat (ht) @(negedge clk);
            ticket = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < nc; k++) begin
            one_output = 1'b1;
            @(negedge clk);
            one_output = 1'b0;
            @(negedge clk);
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!result_valid && n < 200);
        check("rv_seen", 32'(result_valid), 1);
        if (nt == 0 && nc == 0) check("rv_latency", n, T + 1);
        @(posedge clk); #1;
        check("back_idle", 32'({busy, result_valid}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_outs", 32'({busy, done, ten_insert, one_insert, result_valid}), 0);
        check("rst_vals", 32'({dest, count, tickets_rcvd, change_rcvd}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        dest_in = 8'd7; count_in = 8'd2; pay_in = 8'd12; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_ten", 32'(ten_insert), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 32'({ten_insert, done, busy}), 0);
        check("async_rst_dest", 32'({dest, count}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst", 32'({busy, done, ten_insert, one_insert, result_valid}), 0);

        run(8'd15, 8'd3, 8'd12, 3, 1, 6, 1'b0);
        @(negedge clk);
        ticket = 1'b1;
        @(negedge clk);
        ticket = 1'b0;
        @(posedge clk); #1;
        check("idle_no_count", 32'(tickets_rcvd), 3);

        run(8'd1, 8'd1, 8'd0, 0, 1, 0, 1'b0);
        run(8'd2, 8'd1, 8'd5, 1, 5, 0, 1'b0);
        run(8'd3, 8'd9, 8'd0, 0, 1, 300, 1'b0);
        run(8'd44, 8'd2, 8'd3, 2, 1, 1, 1'b1);
        run(8'd9, 8'd4, 8'd25, 4, 2, 5, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
